// File: rtl/delta_pkg.sv
// ============================================================================
// Module   : delta_pkg
// Purpose  : Shared widths and event-word field layout for the delta-spike
//            event path (event FIFO, serializer, test bench).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package delta_pkg;

    localparam int DATA_W = 8;              // delta value width
    localparam int TS_W   = 8;              // timestamp width
    localparam int EVT_W  = TS_W + DATA_W;  // event word width

    // Event word layout: {timestamp, delta}
    localparam int EVT_DELTA_LSB = 0;
    localparam int EVT_TS_LSB    = DATA_W;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_reg.sv
// ============================================================================
// Module   : sync_fifo_reg
// Purpose  : Register-array FIFO with occupancy count. Head entry is presented
//            combinationally; reads as zero when empty.
// Ports    : clk, rst_n (async active-low), clr (sync flush, highest priority)
//            push/wdata  - write request (accepted if not full or popping)
//            pop         - read request (ignored when empty)
//            rdata       - head entry
//            count/full/empty - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_reg #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;

    logic w_push_ok;
    logic w_pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // A pop frees the slot the push needs, so a full FIFO still accepts
    // a push in the same cycle as a pop.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/delta_event_fifo.sv
// ============================================================================
// Module   : delta_event_fifo
// Purpose  : Turns nonzero per-cycle delta values into timestamped event words
//            {ts, delta}, buffers them, and hands them to a consumer over a
//            valid/ready handshake. Events arriving while full are dropped,
//            flagged (sticky overflow) and counted (saturating drop_cnt).
// Ports    : clk, rst_n (async active-low)
//            en          - capture and timestamp enable
//            clr         - sync flush of FIFO, timestamp and drop statistics
//            diff_in     - delta from spike stage, 0 = no spike
//            evt_valid / evt_ready / evt_data - event output handshake
//            fifo_count  - occupied entries
//            overflow    - sticky drop flag
//            drop_cnt    - saturating dropped-event count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delta_event_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = delta_pkg::DATA_W,
    parameter  int TS_W   = delta_pkg::TS_W,
    parameter  int DROP_W = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic [DATA_W-1:0]      diff_in,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [TS_W+DATA_W-1:0] evt_data,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    import delta_pkg::*;

    logic [TS_W-1:0]   ts_q,       ts_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    logic w_push_req;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign w_push_req = en & (diff_in != '0);
    assign evt_valid  = ~w_empty;
    assign w_pop      = evt_valid & evt_ready;

    // Dropped only when full with no simultaneous pop; a flush discards
    // the incoming event without counting it.
    assign w_drop = w_push_req & w_full & ~w_pop & ~clr;

    sync_fifo_reg #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (w_push_req),
        .pop   (w_pop),
        .wdata ({ts_q, diff_in}),
        .rdata (evt_data),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        ts_d       = ts_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clr) begin
            ts_d       = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (en) begin
                ts_d = ts_q + TS_W'(1);
            end
            if (w_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {DROP_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_delta_event_fifo.sv
// ============================================================================
// Module   : tb_delta_event_fifo
// Purpose  : Self-checking bench for delta_event_fifo. A queue-based event
//            model produces expected events; a monitor compares outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delta_event_fifo;

    import delta_pkg::*;

    localparam int DEPTH    = 8;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;
    localparam int TS_MOD   = 1 << TS_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic [DATA_W-1:0] diff_in = '0;
    logic              evt_ready = 1'b0;
    logic              evt_valid;
    logic [EVT_W-1:0]  evt_data;
    logic [3:0]        fifo_count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    delta_event_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .TS_W   (TS_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .diff_in    (diff_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the queue holds exactly the events the FIFO should
    // contain, oldest first.
    logic [EVT_W-1:0] sb[$];
    int               ts_m   = 0;
    int               drop_m = 0;
    bit               ovf_m  = 1'b0;
    logic [EVT_W-1:0] last_pop = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle after the posedge; compare at the negedge.
    always @(negedge clk) begin
        chk("evt_valid", {31'd0, evt_valid}, {31'd0, sb.size() != 0});
        chk("fifo_count", {28'd0, fifo_count}, sb.size());
        chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        chk("drop_cnt", {24'd0, drop_cnt}, drop_m);
        if (!evt_valid) chk("evt_data_empty", {16'd0, evt_data}, 32'd0);
        if (evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got 0x%0h expected none", evt_data);
            end else begin
                chk("evt_data", {16'd0, evt_data}, {16'd0, sb[0]});
                last_pop = evt_data;
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; model advanced after the monitor's pop.
    task automatic cyc(input bit e, input bit c, input logic [DATA_W-1:0] d, input bit r);
        logic [TS_W-1:0] t;
        #2;
        en = e; clr = c; diff_in = d; evt_ready = r;
        @(negedge clk);
        #1;
        if (c) begin
            sb.delete();
            ts_m = 0; drop_m = 0; ovf_m = 1'b0;
        end else if (e) begin
            if (d != 0) begin
                t = TS_W'(ts_m);
                if (sb.size() < DEPTH) sb.push_back({t, d});
                else begin
                    ovf_m = 1'b1;
                    if (drop_m < DROP_MAX) drop_m++;
                end
            end
            ts_m = (ts_m + 1) % TS_MOD;
        end
        @(posedge clk);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_data", {16'd0, evt_data}, 32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);

        // Single event after 5 idle timestamps
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'd0, 1);
        cyc(1, 0, 8'd12, 1);
        cyc(1, 0, 8'd0, 1);
        cyc(1, 0, 8'd0, 1);
        chk("first_event", {16'd0, last_pop}, 32'h050C);

        // Fill, overflow, full push+pop, drain
        cyc(1, 1, 8'd0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, DATA_W'(10 + i), 0);
        #1 chk("fill_count", {28'd0, fifo_count}, 32'd8);
        chk("fill_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'd99, 0);
        #1 chk("drop3", {24'd0, drop_cnt}, 32'd3);
        cyc(1, 0, 8'd18, 1);
        #1 chk("full_pushpop_count", {28'd0, fifo_count}, 32'd8);
        for (int i = 0; i < 10; i++) cyc(0, 0, 8'd0, 1);
        chk("appended_last", {16'd0, last_pop}, 32'h0B12);

        // Timestamp wrap and enable hold
        cyc(1, 1, 8'd0, 1);
        for (int i = 0; i < 256; i++) cyc(1, 0, 8'd0, 1);
        cyc(1, 0, 8'd20, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'd5, 1);
        chk("wrap_event", {16'd0, last_pop}, 32'h0014);
        cyc(1, 0, 8'd7, 1);
        cyc(1, 0, 8'd0, 1);
        chk("hold_event", {16'd0, last_pop}, 32'h0107);

        // Drop counter saturation, then flush with a concurrent spike
        cyc(1, 1, 8'd0, 0);
        for (int i = 0; i < 308; i++) cyc(1, 0, 8'd1, 0);
        #1 chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
        cyc(1, 1, 8'd9, 0);
        #1 chk("clr_count", {28'd0, fifo_count}, 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_drop", {24'd0, drop_cnt}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 9) != 0),
                ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 4) ? DATA_W'($urandom_range(1, 255)) : 8'd0,
                $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset mid-burst
        cyc(1, 1, 8'd0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, DATA_W'(30 + i), 0);
        cyc(1, 0, 8'd50, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, evt_valid}, 32'd0);
        chk("arst_count", {28'd0, fifo_count}, 32'd0);
        chk("arst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("arst_data", {16'd0, evt_data}, 32'd0);
        sb.delete();
        ts_m = 0; drop_m = 0; ovf_m = 1'b0;
        en = 1'b0; clr = 1'b0; diff_in = '0; evt_ready = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        cyc(1, 0, 8'd3, 1);
        cyc(1, 0, 8'd0, 1);
        cyc(1, 0, 8'd0, 1);
        chk("post_reset_event", {16'd0, last_pop}, 32'h0003);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_events: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
